game_ctrl: RTL and testbench

Top-level game sequencer for the Yoshi egg-collecting VGA game. It moves the game through title, clear, play and game-over phases, and runs the per-second countdown from the VGA frame tick. It gates Yoshi motion and egg collision through `play_en`, issues a one-cycle clear to the eggs/score datapath, and keeps the session high score. It sits beside the VGA sync, Yoshi and eggs blocks and feeds the HUD/text overlay.

---
 rtl/game_pkg.sv | 20 ++
 rtl/game_timer.sv | 52 +++++
 rtl/game_ctrl.sv | 119 +++++++++++
 tb/tb_game_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the Yoshi game sequencer, timer and score path.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } game_state_e;

  localparam int unsigned GAME_SECONDS_DEF     = 60;
  localparam int unsigned FRAMES_PER_SEC_DEF   = 60;
  localparam int unsigned OVER_HOLD_FRAMES_DEF = 180;

  localparam int SCORE_W = 14;  // 0..9999, shared with eggs and score display
  localparam int TIME_W  = 7;   // seconds, up to 127
  localparam int FRAME_W = 6;   // frame-in-second count, up to 63
  localparam int HOLD_W  = 8;   // game-over hold frames, up to 255

endpackage

// File: rtl/game_timer.sv
// Per-second countdown driven by the VGA frame tick; expire pulses on the 1->0 second.
module game_timer
  import game_pkg::*;
#(
  parameter int unsigned GAME_SECONDS   = GAME_SECONDS_DEF,
  parameter int unsigned FRAMES_PER_SEC = FRAMES_PER_SEC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              run,
  input  logic              frame_tick,
  output logic [TIME_W-1:0] time_left,
  output logic              expire
);

  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [TIME_W-1:0]  time_left_q, time_left_d;
  logic               sec_wrap;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    frame_cnt_d = frame_cnt_q;
    time_left_d = time_left_q;
    sec_wrap    = run && frame_tick && (frame_cnt_q == FRAME_W'(FRAMES_PER_SEC - 1));
    if (load) begin
      frame_cnt_d = '0;
      time_left_d = TIME_W'(GAME_SECONDS);
    end else if (sec_wrap) begin
      frame_cnt_d = '0;
      time_left_d = time_left_q - TIME_W'(1);
    end else if (run && frame_tick) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  // Combinational so the FSM leaves PLAY on the same edge as the final tick.
  assign expire    = sec_wrap && (time_left_q == TIME_W'(1));
  assign time_left = time_left_q;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      frame_cnt_q <= '0;
      time_left_q <= TIME_W'(GAME_SECONDS);
    end else begin
      frame_cnt_q <= frame_cnt_d;
      time_left_q <= time_left_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: title/clear/play/over phases, start edge detect, game-over hold and high score.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned GAME_SECONDS     = GAME_SECONDS_DEF,
  parameter int unsigned FRAMES_PER_SEC   = FRAMES_PER_SEC_DEF,
  parameter int unsigned OVER_HOLD_FRAMES = OVER_HOLD_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               new_score,
  input  logic [SCORE_W-1:0] score,
  output logic               play_en,
  output logic               game_clear,
  output logic [1:0]         state,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic               title_on,
  output logic               gameover_on
);

  game_state_e        state_q, state_d;
  logic               start_d_q, start_rise, expire;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               hs_done_q, hs_done_d;
  logic [SCORE_W-1:0] high_score_q, high_score_d;
  logic               new_high_q, new_high_d;
  logic               play_en_q, game_clear_q, title_on_q, gameover_on_q;

  // The HUD flash counter lives elsewhere; the pulse is not part of sequencing.
  logic unused_new_score;
  assign unused_new_score = new_score;

  assign start_rise = start_btn & ~start_d_q;

  game_timer #(
    .GAME_SECONDS  (GAME_SECONDS),
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == CLEAR),
    .run       (state_q == PLAY),
    .frame_tick(frame_tick),
    .time_left (time_left),
    .expire    (expire)
  );

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    hs_done_d    = hs_done_q;
    high_score_d = high_score_q;
    new_high_d   = new_high_q;
    case (state_q)
      IDLE:  if (start_rise) state_d = CLEAR;
      CLEAR: begin
        new_high_d = 1'b0;
        state_d    = PLAY;
      end
      PLAY: if (expire) begin
        state_d    = OVER;
        hold_cnt_d = HOLD_W'(OVER_HOLD_FRAMES);
        hs_done_d  = 1'b0;
      end
      OVER: begin
        // Compare on the first tick so a score landing on the final PLAY cycle is seen.
        if (frame_tick && !hs_done_q) begin
          hs_done_d = 1'b1;
          if (score > high_score_q) begin
            high_score_d = score;
            new_high_d   = 1'b1;
          end
        end
        if (frame_tick && (hold_cnt_q != '0)) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        if (start_rise && (hold_cnt_q == '0)) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      start_d_q     <= 1'b1;  // a button held through reset must not look like a press
      hold_cnt_q    <= '0;
      hs_done_q     <= 1'b0;
      high_score_q  <= '0;
      new_high_q    <= 1'b0;
      play_en_q     <= 1'b0;
      game_clear_q  <= 1'b0;
      title_on_q    <= 1'b1;
      gameover_on_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_d_q     <= start_btn;
      hold_cnt_q    <= hold_cnt_d;
      hs_done_q     <= hs_done_d;
      high_score_q  <= high_score_d;
      new_high_q    <= new_high_d;
      play_en_q     <= (state_d == PLAY);
      game_clear_q  <= (state_d == CLEAR);
      title_on_q    <= (state_d == IDLE);
      gameover_on_q <= (state_d == OVER);
    end
  end

  assign state       = state_q;
  assign play_en     = play_en_q;
  assign game_clear  = game_clear_q;
  assign title_on    = title_on_q;
  assign gameover_on = gameover_on_q;
  assign high_score  = high_score_q;
  assign new_high    = new_high_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random stimulus against a phase-level model.
module tb_game_ctrl;

  localparam int GS   = 3;
  localparam int FPS  = 4;
  localparam int HOLD = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start_btn = 1'b1;
  logic        new_score = 1'b0;
  logic [13:0] score = '0;
  logic        play_en, game_clear, new_high, title_on, gameover_on;
  logic [1:0]  state;
  logic [6:0]  time_left;
  logic [13:0] high_score;

  int vectors = 0;
  int miscompares = 0;

  game_ctrl #(
    .GAME_SECONDS    (GS),
    .FRAMES_PER_SEC  (FPS),
    .OVER_HOLD_FRAMES(HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .new_score  (new_score),
    .score      (score),
    .play_en    (play_en),
    .game_clear (game_clear),
    .state      (state),
    .time_left  (time_left),
    .high_score (high_score),
    .new_high   (new_high),
    .title_on   (title_on),
    .gameover_on(gameover_on)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus counts of ticks seen in PLAY and OVER.
  int m_phase, m_ticks, m_over_ticks, m_time, m_hs;
  bit m_nh, m_prev;

  function automatic void model_reset();
    m_phase = 0; m_ticks = 0; m_over_ticks = 0;
    m_time = GS; m_hs = 0; m_nh = 1'b0; m_prev = 1'b1;
  endfunction

  function automatic void model_step();
    bit rise;
    int old;
    rise   = start_btn && !m_prev;
    m_prev = start_btn;
    case (m_phase)
      0: if (rise) m_phase = 1;
      1: begin m_nh = 1'b0; m_ticks = 0; m_time = GS; m_phase = 2; end
      2: if (frame_tick) begin
        m_ticks++;
        m_time = GS - m_ticks / FPS;
        if (m_ticks == GS * FPS) begin m_phase = 3; m_over_ticks = 0; end
      end
      default: begin
        old = m_over_ticks;
        if (frame_tick) begin
          if (old == 0 && int'(score) > m_hs) begin m_hs = int'(score); m_nh = 1'b1; end
          m_over_ticks++;
        end
        if (rise && old >= HOLD) m_phase = 1;
      end
    endcase
  endfunction

  function automatic logic [28:0] exp_vec();
    return {2'(m_phase), m_phase == 2, m_phase == 1, m_phase == 0, m_phase == 3,
            7'(m_time), 14'(m_hs), m_nh};
  endfunction

  function automatic logic [28:0] dut_vec();
    return {state, play_en, game_clear, title_on, gameover_on, time_left, high_score, new_high};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    end
  endtask

  task automatic press();
    start_btn = 1'b0; step(); start_btn = 1'b1; step(); start_btn = 1'b0;
  endtask

  task automatic test_reset();
    start_btn = 1'b1; reset = 1'b1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (state !== 2'd0 || title_on !== 1'b1 || time_left !== 7'(GS) || play_en !== 1'b0 ||
        high_score !== 14'd0 || new_high !== 1'b0 || gameover_on !== 1'b0 || game_clear !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_vec());
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_tick = (i == 1);
      step();
      vectors++;
      if (state !== 2'd0 || title_on !== 1'b1) begin
        miscompares++;
        $display("FAIL held_start_idle: state %0d title_on %0b, required 0 and 1", state, title_on);
      end
    end
    frame_tick = 1'b0;
    start_btn = 1'b0; step();
    start_btn = 1'b1; step();
    vectors++;
    if (state !== 2'd1 || game_clear !== 1'b1 || play_en !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_pulse: state %0d game_clear %0b, required 1 and 1", state, game_clear);
    end
    step();
    vectors++;
    if (state !== 2'd2 || play_en !== 1'b1 || game_clear !== 1'b0 || time_left !== 7'(GS)) begin
      miscompares++;
      $display("FAIL enter_play: got %h expected %h", dut_vec(), exp_vec());
    end
    start_btn = 1'b0;
  endtask

  // Countdown with a score pulse on the final tick; score moves 80->100 afterwards.
  task automatic test_countdown();
    score = 14'd80;
    for (int t = 1; t <= GS * FPS; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        vectors++;
        if (dut_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL countdown_gap t=%0d: got %h expected %h", t, dut_vec(), exp_vec());
        end
      end
      if (t == 3) start_btn = 1'b1;  // a press during PLAY is ignored
      frame_tick = 1'b1;
      new_score = (t == GS * FPS);
      step();
      frame_tick = 1'b0; new_score = 1'b0; start_btn = 1'b0;
      if (t == GS * FPS) score = 14'd100;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL countdown_vec t=%0d: got %h expected %h", t, dut_vec(), exp_vec());
      end
      if (t % FPS == 0) begin
        vectors++;
        if (time_left !== 7'(GS - t / FPS)) begin
          miscompares++;
          $display("FAIL countdown_step t=%0d: time_left %0d, required %0d", t, time_left, GS - t / FPS);
        end
      end
    end
    vectors++;
    if (state !== 2'd3 || play_en !== 1'b0 || gameover_on !== 1'b1 || time_left !== 7'd0) begin
      miscompares++;
      $display("FAIL game_over_entry: state %0d play_en %0b time_left %0d, required 3 0 0", state, play_en, time_left);
    end
  endtask

  task automatic test_final_tick_score();
    vectors++;
    if (high_score !== 14'd0) begin
      miscompares++;
      $display("FAIL hs_before_tick: high_score %0d, required 0", high_score);
    end
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    vectors++;
    if (high_score !== 14'd100 || new_high !== 1'b1) begin
      miscompares++;
      $display("FAIL final_tick_score: high_score %0d new_high %0b, required 100 and 1", high_score, new_high);
    end
  endtask

  task automatic test_hold();
    score = 14'd9000;  // only the first OVER tick may latch a score
    step();
    tick_n(1);                                       // hold tick 2
    start_btn = 1'b1; frame_tick = 1'b1; step();     // hold tick 3 with press
    frame_tick = 1'b0; start_btn = 1'b0;
    vectors++;
    if (state !== 2'd3) begin
      miscompares++;
      $display("FAIL hold_press_ignored: state %0d, required 3", state);
    end
    step();
    tick_n(1);                                       // hold tick 4
    start_btn = 1'b1; frame_tick = 1'b1; step();     // hold tick 5 (1->0) with press
    frame_tick = 1'b0; start_btn = 1'b0;
    vectors++;
    if (state !== 2'd3 || high_score !== 14'd100) begin
      miscompares++;
      $display("FAIL hold_last_tick_press: state %0d high_score %0d, required 3 and 100", state, high_score);
    end
    step();
    press();
    vectors++;
    if (state !== 2'd1 || game_clear !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release_press: state %0d game_clear %0b, required 1 and 1", state, game_clear);
    end
    step();
    vectors++;
    if (state !== 2'd2 || time_left !== 7'(GS) || new_high !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_time: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_high_score();
    score = 14'd120;
    tick_n(GS * FPS);
    tick_n(1);
    vectors++;
    if (high_score !== 14'd120 || new_high !== 1'b1) begin
      miscompares++;
      $display("FAIL hs_raise: high_score %0d new_high %0b, required 120 and 1", high_score, new_high);
    end
    tick_n(HOLD);
    press();
    step();
    tick_n(GS * FPS);
    tick_n(1);
    vectors++;
    if (high_score !== 14'd120 || new_high !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL hs_equal: high_score %0d new_high %0b, required 120 and 0", high_score, new_high);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) start_btn = ~start_btn;
      frame_tick = ($urandom_range(0, 2) == 0);
      new_score  = ($urandom_range(0, 7) == 0);
      score      = 14'($urandom_range(0, 400));
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_vec cyc=%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    frame_tick = 1'b0; new_score = 1'b0; start_btn = 1'b0;
  endtask

  task automatic test_reset_mid_play();
    reset = 1'b1; model_reset(); #2; reset = 1'b0;
    press(); step();
    score = 14'd50;
    tick_n(GS * FPS + 1 + HOLD);
    press(); step();
    tick_n(FPS);
    vectors++;
    if (state !== 2'd2 || time_left !== 7'(GS - 1) || high_score !== 14'd50) begin
      miscompares++;
      $display("FAIL pre_reset_play: got %h expected %h", dut_vec(), exp_vec());
    end
    reset = 1'b1; model_reset();
    #1;
    vectors++;
    if (state !== 2'd0 || play_en !== 1'b0 || time_left !== 7'(GS) || high_score !== 14'd0 || title_on !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_play: got %h expected %h", dut_vec(), exp_vec());
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame_tick = (i[0] == 1'b0);
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL after_reset cyc=%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_final_tick_score();
    test_hold();
    test_high_score();
    test_random();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
